seq_muldiv: RTL and testbench

Multi-cycle, parametrised multiply/divide unit for the ALU datapath. It executes unsigned or signed multiply (shift-add) and divide (restoring) over WIDTH iterations, one bit per clock. It returns a double-width product or a quotient/remainder pair with status flags. It sits beside the combinational add/sub/shift paths and is started by the ALU control through a valid/ready handshake.

---
 rtl/seq_muldiv.sv | 162 ++++++++++++++++
 tb/tb_seq_muldiv.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// Sequential multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, signed ops via magnitude arithmetic plus sign fix-up.
module seq_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [1:0]       status
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [1:0]         status_q, status_d;

    logic               s1, s2;
    logic [WIDTH-1:0]   m1, m2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, trial;
    logic [2*WIDTH-1:0] step, prod;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    // Operand magnitudes and one iteration of either algorithm.
    always_comb begin
        s1 = opcode[0] & operand1[WIDTH-1];
        s2 = opcode[0] & operand2[WIDTH-1];
        m1 = s1 ? -operand1 : operand1;
        m2 = s2 ? -operand2 : operand2;

        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opd_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opd_q};

        if (is_div_q) begin
            // trial[WIDTH] is the borrow: clear means the subtraction stands
            step = {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end

        prod = neg_res_q ? -step : step;
        quo  = neg_res_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem  = neg_rem_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

        if (!is_div_q) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            fin_hi = op1_q;
            fin_lo = '1;
        end else begin
            fin_hi = rem;
            fin_lo = quo;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        op1_d     = op1_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        status_d  = status_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    is_div_d  = opcode[1];
                    neg_res_d = s1 ^ s2;
                    neg_rem_d = s1;
                    op1_d     = operand1;
                    dz_d      = opcode[1] && (operand2 == '0);
                    acc_d     = {{WIDTH{1'b0}}, (opcode[1] ? m1 : m2)};
                    opd_d     = opcode[1] ? m2 : m1;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    res_hi_d = fin_hi;
                    res_lo_d = fin_lo;
                    status_d = {dz_q, (fin_hi == '0) && (fin_lo == '0)};
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            op1_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            op1_q     <= op1_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            status_q  <= status_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign status    = status_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv at WIDTH=8 and WIDTH=16.
module tb_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  opcode = '0;
    logic [7:0]  operand1 = '0, operand2 = '0;
    logic        in_ready, out_valid;
    logic [7:0]  result_hi, result_lo;
    logic [1:0]  status;

    logic        in_valid_w = 1'b0, out_ready_w = 1'b0;
    logic [1:0]  opcode_w = '0;
    logic [15:0] operand1_w = '0, operand2_w = '0;
    logic        in_ready_w, out_valid_w;
    logic [15:0] result_hi_w, result_lo_w;
    logic [1:0]  status_w;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_hi(result_hi), .result_lo(result_lo), .status(status)
    );

    seq_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .opcode(opcode_w), .operand1(operand1_w), .operand2(operand2_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result_hi(result_hi_w), .result_lo(result_lo_w), .status(status_w)
    );

    // Issue one 8-bit op from IDLE (called #1 after an edge), check latency and results.
    task automatic do_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eh, input logic [7:0] el, input logic [1:0] es,
                          input string nm);
        int lat;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready: got %b expected 1", nm, in_ready);
        end
        opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; operand1 = ~a; operand2 = ~b;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run += 4;
        if (lat !== 8) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected 8", nm, lat);
        end
        if (result_hi !== eh) begin
            tests_failed++;
            $display("FAIL %s hi: got %h expected %h", nm, result_hi, eh);
        end
        if (result_lo !== el) begin
            tests_failed++;
            $display("FAIL %s lo: got %h expected %h", nm, result_lo, el);
        end
        if (status !== es) begin
            tests_failed++;
            $display("FAIL %s status: got %b expected %b", nm, status, es);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s handoff: got valid=%b ready=%b expected valid=0 ready=1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic do_op16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eh, input logic [15:0] el, input string nm);
        int lat;
        opcode_w = op; operand1_w = a; operand2_w = b; in_valid_w = 1'b1;
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        lat = 0;
        while (out_valid_w !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run += 3;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected 16", nm, lat);
        end
        if (result_hi_w !== eh) begin
            tests_failed++;
            $display("FAIL %s hi: got %h expected %h", nm, result_hi_w, eh);
        end
        if (result_lo_w !== el) begin
            tests_failed++;
            $display("FAIL %s lo: got %h expected %h", nm, result_lo_w, el);
        end
        out_ready_w = 1'b1;
        @(posedge clk); #1;
        out_ready_w = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_hi !== 8'h00 ||
            result_lo !== 8'h00 || status !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset: got ready=%b valid=%b hi=%h lo=%h st=%b expected 1 0 00 00 00",
                     in_ready, out_valid, result_hi, result_lo, status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        do_op8(2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 2'b00, "mulu_ff_ff");
        do_op8(2'b01, 8'hFD, 8'h05, 8'hFF, 8'hF1, 2'b00, "muls_m3_5");
        do_op8(2'b01, 8'h00, 8'h80, 8'h00, 8'h00, 2'b01, "muls_0_m128");
    endtask

    task automatic test_div;
        do_op8(2'b10, 8'd200, 8'd7, 8'h04, 8'h1C, 2'b00, "divu_200_7");
        do_op8(2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, 2'b00, "divs_m7_2");
        do_op8(2'b10, 8'h2A, 8'h00, 8'h2A, 8'hFF, 2'b10, "divu_by_zero");
        do_op8(2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 2'b00, "divs_overflow");
    endtask

    task automatic test_back_to_back;
        int lat;
        opcode = 2'b00; operand1 = 8'd3; operand2 = 8'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                result_hi !== 8'h00 || result_lo !== 8'h0C) begin
                tests_failed++;
                $display("FAIL stall%0d: got valid=%b ready=%b hi=%h lo=%h expected 1 0 00 0c",
                         i, out_valid, in_ready, result_hi, result_lo);
            end
            @(posedge clk); #1;
        end
        opcode = 2'b10; operand1 = 8'd100; operand2 = 8'd10; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_lo !== 8'h0C) begin
            tests_failed++;
            $display("FAIL release: got valid=%b ready=%b lo=%h expected 0 1 0c",
                     out_valid, in_ready, result_lo);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reaccept: got ready=%b expected 0", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat !== 8 || result_hi !== 8'h00 || result_lo !== 8'h0A) begin
            tests_failed++;
            $display("FAIL b2b_div: got lat=%0d hi=%h lo=%h expected 8 00 0a",
                     lat, result_hi, result_lo);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc;
        opcode = 2'b00; operand1 = 8'hFF; operand2 = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_hi !== 8'h00 ||
            result_lo !== 8'h00 || status !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_reset: got ready=%b valid=%b hi=%h lo=%h st=%b expected 1 0 00 00 00",
                     in_ready, out_valid, result_hi, result_lo, status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op8(2'b10, 8'd200, 8'd7, 8'h04, 8'h1C, 2'b00, "after_reset_divu");
    endtask

    task automatic test_width16;
        do_op16(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, "w16_mulu");
        do_op16(2'b10, 16'd50000, 16'd300, 16'h00C8, 16'h00A6, "w16_divu");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_calc();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
